// File: rtl/instr_feeder.sv
// Program-memory instruction source for the multicycle processor.
// Issues one word per Run strobe, appends mvi immediates, paces on Done and stops on a halt sentinel.
module instr_feeder #(
  parameter int         ADDR_WIDTH = 5,
  parameter logic [2:0] OP_MVI     = 3'b001,
  parameter logic [2:0] OP_HALT    = 3'b111,
  parameter int         TIMEOUT    = 16
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic                  LoadEn,
  input  logic [ADDR_WIDTH-1:0] LoadAddr,
  input  logic [15:0]           LoadData,
  input  logic                  Done,
  output logic [15:0]           DIN,
  output logic                  Run,
  output logic                  Busy,
  output logic                  Halted,
  output logic                  Error,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [15:0]           InstrCount
);

  localparam int DEPTH       = 1 << ADDR_WIDTH;
  localparam int TIMER_WIDTH = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    IMM,
    WAIT,
    HALT,
    ERROR
  } state_t;

  state_t                 state;
  logic [15:0]            mem [DEPTH];
  logic [15:0]            word_reg;
  logic [TIMER_WIDTH-1:0] timer;
  logic [ADDR_WIDTH-1:0]  pc_plus1;
  logic [ADDR_WIDTH-1:0]  pc_plus2;
  logic [15:0]            fetch_word;
  logic [15:0]            next_word;

  assign pc_plus1   = PC + ADDR_WIDTH'(1);
  assign pc_plus2   = PC + ADDR_WIDTH'(2);
  assign fetch_word = mem[PC];
  assign next_word  = mem[pc_plus1];
  assign DIN        = word_reg;

  // Loads are refused while a program is executing so the running code cannot be modified under it.
  always_ff @(posedge Clock) begin
    if (LoadEn && !Busy) begin
      mem[LoadAddr] <= LoadData;
    end
  end

  // timer holds the number of cycles elapsed since the Run cycle; it reads 1 in the first IMM/WAIT cycle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      PC         <= '0;
      word_reg   <= '0;
      timer      <= '0;
      InstrCount <= '0;
      Run        <= 1'b0;
      Busy       <= 1'b0;
      Halted     <= 1'b0;
      Error      <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT, ERROR: begin
          if (Start) begin
            state      <= FETCH;
            PC         <= '0;
            InstrCount <= '0;
            Busy       <= 1'b1;
            Halted     <= 1'b0;
            Error      <= 1'b0;
          end
        end
        FETCH: begin
          if (fetch_word[8:6] == OP_HALT) begin
            state  <= HALT;
            Busy   <= 1'b0;
            Halted <= 1'b1;
          end else begin
            state    <= ISSUE;
            word_reg <= fetch_word;
            Run      <= 1'b1;
          end
        end
        ISSUE: begin
          Run   <= 1'b0;
          timer <= TIMER_WIDTH'(1);
          if (word_reg[8:6] == OP_MVI) begin
            word_reg <= next_word;
            PC       <= pc_plus2;
            state    <= IMM;
          end else begin
            PC    <= pc_plus1;
            state <= WAIT;
          end
        end
        IMM, WAIT: begin
          // A Done arriving in the same cycle the timer expires still completes the instruction.
          if (Done) begin
            InstrCount <= InstrCount + 16'd1;
            state      <= FETCH;
          end else if (timer == TIMER_WIDTH'(TIMEOUT)) begin
            state <= ERROR;
            Busy  <= 1'b0;
            Error <= 1'b1;
          end else begin
            timer <= timer + TIMER_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          Run   <= 1'b0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: directed vector table, random programs against a sequential program model,
// and hand-written sequences for watchdog, reset, load-while-busy and address wrap.
module tb_instr_feeder;

  localparam int          TIMEOUT   = 16;
  localparam logic [15:0] HALT_WORD = 16'h01C0;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start, load_en, done;
  logic [4:0]  load_addr;
  logic [15:0] load_data;
  logic [15:0] din;
  logic        run, busy, halted, error;
  logic [4:0]  pc;
  logic [15:0] instr_count;

  logic        start_w, load_en_w, done_w;
  logic [1:0]  load_addr_w, pc_w;
  logic [15:0] load_data_w, din_w, instr_count_w;
  logic        run_w, busy_w, halted_w, error_w;

  int checks = 0;
  int errors = 0;

  logic [15:0] obs_run[$];
  logic [15:0] obs_next[$];
  bit          obs_hold[$];

  logic [15:0] ref_mem[32];
  logic [15:0] exp_run[$];
  logic [15:0] exp_next[$];
  logic [4:0]  exp_pc;
  int          exp_count;
  bit          exp_halts;

  typedef struct {
    string       name;
    logic [15:0] w0, w1, w2;
    int          delay;
    int          exp_runs;
    logic [15:0] exp_din0, exp_next0;
    logic [4:0]  exp_pc;
    int          exp_count;
  } vec_t;

  vec_t vecs[5];

  always #5 clock = ~clock;

  instr_feeder dut (
    .Clock(clock), .Resetn(resetn), .Start(start), .LoadEn(load_en),
    .LoadAddr(load_addr), .LoadData(load_data), .Done(done),
    .DIN(din), .Run(run), .Busy(busy), .Halted(halted), .Error(error),
    .PC(pc), .InstrCount(instr_count)
  );

  instr_feeder #(.ADDR_WIDTH(2)) dut_wrap (
    .Clock(clock), .Resetn(resetn), .Start(start_w), .LoadEn(load_en_w),
    .LoadAddr(load_addr_w), .LoadData(load_data_w), .Done(done_w),
    .DIN(din_w), .Run(run_w), .Busy(busy_w), .Halted(halted_w), .Error(error_w),
    .PC(pc_w), .InstrCount(instr_count_w)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [4:0] addr, input logic [15:0] data);
    load_addr = addr;
    load_data = data;
    load_en   = 1'b1;
    step();
    load_en   = 1'b0;
  endtask

  task automatic load_word_w(input logic [1:0] addr, input logic [15:0] data);
    load_addr_w = addr;
    load_data_w = data;
    load_en_w   = 1'b1;
    step();
    load_en_w   = 1'b0;
  endtask

  // Pulses Start, then answers each Run with Done after 'fixed_delay' cycles (random 1..5 when 0).
  task automatic run_loop(input int fixed_delay, input int max_cycles, output bit finished);
    int          r_cycle, d;
    logic [15:0] hold_val;
    bit          hold_bad;
    obs_run.delete();
    obs_next.delete();
    obs_hold.delete();
    finished = 1'b0;
    r_cycle  = -100;
    d        = 1;
    hold_val = '0;
    hold_bad = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      if (halted || error) begin
        finished = 1'b1;
        break;
      end
      if (run) begin
        r_cycle = c;
        obs_run.push_back(din);
        d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 5));
      end else if (c == r_cycle + 1) begin
        hold_val = din;
        hold_bad = 1'b0;
        obs_next.push_back(din);
      end else if (c > r_cycle + 1 && c <= r_cycle + d && din !== hold_val) begin
        hold_bad = 1'b1;
      end
      done = (c == r_cycle + d);
      if (c == r_cycle + d) obs_hold.push_back(!hold_bad);
      step();
    end
    done = 1'b0;
  endtask

  task automatic wait_run(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (run) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic drain_to_halt(input int budget, output bit ok);
    ok   = 1'b0;
    done = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (halted) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    done = 1'b0;
  endtask

  // Reference: walk the program word by word; an mvi consumes the following word as its operand.
  task automatic model_program();
    int          p;
    logic [15:0] w;
    logic [2:0]  op;
    p = 0;
    exp_run.delete();
    exp_next.delete();
    exp_count = 0;
    exp_halts = 1'b0;
    for (int s = 0; s < 40; s++) begin
      w  = ref_mem[p];
      op = w[8:6];
      if (op == 3'b111) begin
        exp_halts = 1'b1;
        break;
      end
      exp_run.push_back(w);
      if (op == 3'b001) begin
        exp_next.push_back(ref_mem[(p + 1) % 32]);
        p = (p + 2) % 32;
      end else begin
        exp_next.push_back(w);
        p = (p + 1) % 32;
      end
      exp_count++;
    end
    exp_pc = 5'(p);
  endtask

  task automatic gen_program();
    int          h, pick;
    logic [15:0] w;
    h = int'($urandom_range(3, 24));
    for (int a = 0; a < 32; a++) begin
      w    = 16'($urandom);
      pick = int'($urandom_range(0, 9));
      w[8:6] = (pick < 3) ? 3'b001 : 3'($urandom_range(0, 6));
      ref_mem[a] = w;
    end
    ref_mem[h] = HALT_WORD | (16'($urandom) & 16'hFE3F);
  endtask

  task automatic applyStimulus(input vec_t v);
    bit fin, hold_all;
    load_word(5'd0, v.w0);
    load_word(5'd1, v.w1);
    load_word(5'd2, v.w2);
    load_word(5'd3, HALT_WORD);
    run_loop(v.delay, 80, fin);
    checkOutput({v.name, " finished"}, 32'(fin), 32'd1);
    checkOutput({v.name, " runs"}, 32'(obs_run.size()), 32'(v.exp_runs));
    if (v.exp_runs > 0 && obs_run.size() > 0 && obs_next.size() > 0) begin
      checkOutput({v.name, " DIN at Run"}, 32'(obs_run[0]), 32'(v.exp_din0));
      checkOutput({v.name, " DIN after Run"}, 32'(obs_next[0]), 32'(v.exp_next0));
      hold_all = 1'b1;
      foreach (obs_hold[i]) if (!obs_hold[i]) hold_all = 1'b0;
      checkOutput({v.name, " DIN stable"}, 32'(hold_all), 32'd1);
    end
    checkOutput({v.name, " PC"}, 32'(pc), 32'(v.exp_pc));
    checkOutput({v.name, " InstrCount"}, 32'(instr_count), 32'(v.exp_count));
    checkOutput({v.name, " Halted"}, 32'(halted), 32'd1);
  endtask

  initial begin
    bit fin, ok, early;
    int run_cycles[$];
    logic [15:0] wrun[$];
    logic [15:0] wnext[$];
    bit last_run;

    resetn = 1'b0;
    start = 1'b0; load_en = 1'b0; done = 1'b0; load_addr = '0; load_data = '0;
    start_w = 1'b0; load_en_w = 1'b0; done_w = 1'b0; load_addr_w = '0; load_data_w = '0;
    #22 resetn = 1'b1;
    step();

    checkOutput("reset DIN", 32'(din), 32'd0);
    checkOutput("reset Run", 32'(run), 32'd0);
    checkOutput("reset Busy", 32'(busy), 32'd0);
    checkOutput("reset Halted", 32'(halted), 32'd0);
    checkOutput("reset Error", 32'(error), 32'd0);
    checkOutput("reset PC", 32'(pc), 32'd0);
    checkOutput("reset InstrCount", 32'(instr_count), 32'd0);

    vecs[0] = '{"mv then halt", 16'h0008, HALT_WORD, 16'h0000, 1, 1, 16'h0008, 16'h0008, 5'd1, 1};
    vecs[1] = '{"mvi",          16'h0040, 16'h00A5, HALT_WORD, 3, 1, 16'h0040, 16'h00A5, 5'd2, 1};
    vecs[2] = '{"halt at 0",    HALT_WORD, 16'h0008, 16'h0008, 1, 0, 16'h0000, 16'h0000, 5'd0, 0};
    vecs[3] = '{"two mv",       16'h0081, 16'h0012, HALT_WORD, 2, 2, 16'h0081, 16'h0081, 5'd2, 2};
    vecs[4] = '{"mvi halt imm", 16'h0040, HALT_WORD, 16'h0008, 1, 2, 16'h0040, HALT_WORD, 5'd3, 2};
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    for (int t = 0; t < 12; t++) begin
      int tries;
      tries = 0;
      do begin
        gen_program();
        model_program();
        tries++;
      end while (!exp_halts && tries < 20);
      for (int a = 0; a < 32; a++) load_word(5'(a), ref_mem[a]);
      run_loop(0, 500, fin);
      checkOutput("random finished", 32'(fin), 32'(exp_halts));
      checkOutput("random runs", 32'(obs_run.size()), 32'(exp_run.size()));
      for (int i = 0; i < exp_run.size() && i < obs_run.size() && i < obs_next.size(); i++) begin
        checkOutput("random DIN at Run", 32'(obs_run[i]), 32'(exp_run[i]));
        checkOutput("random DIN after Run", 32'(obs_next[i]), 32'(exp_next[i]));
      end
      checkOutput("random PC", 32'(pc), 32'(exp_pc));
      checkOutput("random InstrCount", 32'(instr_count), 32'(exp_count));
    end

    // Watchdog: Done never arrives; the last allowed Done cycle is TIMEOUT cycles after Run.
    load_word(5'd0, 16'h0008);
    load_word(5'd1, HALT_WORD);
    done = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    wait_run(10, ok);
    checkOutput("watchdog Run seen", 32'(ok), 32'd1);
    early = 1'b0;
    for (int j = 1; j <= TIMEOUT; j++) begin
      step();
      if (error) early = 1'b1;
    end
    checkOutput("watchdog no early Error", 32'(early), 32'd0);
    checkOutput("watchdog Busy before expiry", 32'(busy), 32'd1);
    step();
    checkOutput("watchdog Error", 32'(error), 32'd1);
    checkOutput("watchdog Busy cleared", 32'(busy), 32'd0);
    checkOutput("watchdog Run low", 32'(run), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    checkOutput("restart clears Error", 32'(error), 32'd0);
    checkOutput("restart Busy", 32'(busy), 32'd1);
    step();
    checkOutput("restart Run", 32'(run), 32'd1);
    checkOutput("restart DIN", 32'(din), 32'h0008);
    drain_to_halt(20, ok);
    checkOutput("restart halts", 32'(ok), 32'd1);

    // Done in the final allowed cycle wins over the watchdog.
    start = 1'b1; step(); start = 1'b0;
    wait_run(10, ok);
    checkOutput("boundary Run seen", 32'(ok), 32'd1);
    for (int j = 1; j <= TIMEOUT; j++) step();
    done = 1'b1;
    step();
    done = 1'b0;
    checkOutput("boundary Done no Error", 32'(error), 32'd0);
    checkOutput("boundary Done counted", 32'(instr_count), 32'd1);
    drain_to_halt(20, ok);
    checkOutput("boundary halts", 32'(ok), 32'd1);

    // Done held high across two instructions: one completion each, Run pulses three cycles apart.
    load_word(5'd0, 16'h0008);
    load_word(5'd1, 16'h0012);
    load_word(5'd2, HALT_WORD);
    done = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    run_cycles.delete();
    for (int c = 0; c < 30; c++) begin
      if (halted) break;
      if (run) run_cycles.push_back(c);
      step();
    end
    done = 1'b0;
    checkOutput("held Done runs", 32'(run_cycles.size()), 32'd2);
    if (run_cycles.size() == 2)
      checkOutput("held Done Run spacing", 32'(run_cycles[1] - run_cycles[0]), 32'd3);
    checkOutput("held Done InstrCount", 32'(instr_count), 32'd2);
    checkOutput("held Done Halted", 32'(halted), 32'd1);

    // Done seen only during ISSUE is stale and must not complete the instruction.
    start = 1'b1; step(); start = 1'b0;
    wait_run(10, ok);
    checkOutput("stale Run seen", 32'(ok), 32'd1);
    done = 1'b1; step();
    done = 1'b0; step();
    checkOutput("stale Done ignored count", 32'(instr_count), 32'd0);
    checkOutput("stale Done still busy", 32'(busy), 32'd1);
    done = 1'b1; step();
    done = 1'b0;
    checkOutput("stale then real Done", 32'(instr_count), 32'd1);
    drain_to_halt(20, ok);
    checkOutput("stale halts", 32'(ok), 32'd1);

    // LoadEn while the program is running is dropped.
    start = 1'b1; step(); start = 1'b0;
    wait_run(10, ok);
    step();
    load_en = 1'b1; load_addr = 5'd1; load_data = 16'hBEEF; done = 1'b1;
    step();
    load_en = 1'b0; done = 1'b0;
    wait_run(10, ok);
    checkOutput("busy load ignored live", 32'(din), 32'h0012);
    drain_to_halt(20, ok);
    run_loop(1, 40, fin);
    checkOutput("busy load rerun finished", 32'(fin), 32'd1);
    if (obs_run.size() == 2) checkOutput("busy load ignored rerun", 32'(obs_run[1]), 32'h0012);
    else checkOutput("busy load rerun runs", 32'(obs_run.size()), 32'd2);

    // Reset during IMM drops outputs at once and keeps memory.
    load_word(5'd0, 16'h0040);
    load_word(5'd1, 16'h00A5);
    load_word(5'd2, HALT_WORD);
    start = 1'b1; step(); start = 1'b0;
    wait_run(10, ok);
    step();
    checkOutput("pre-reset immediate", 32'(din), 32'h00A5);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async reset Run", 32'(run), 32'd0);
    checkOutput("async reset DIN", 32'(din), 32'd0);
    checkOutput("async reset Busy", 32'(busy), 32'd0);
    checkOutput("async reset PC", 32'(pc), 32'd0);
    #2 resetn = 1'b1;
    step();
    run_loop(1, 40, fin);
    checkOutput("post-reset finished", 32'(fin), 32'd1);
    if (obs_run.size() > 0 && obs_next.size() > 0) begin
      checkOutput("memory kept instr", 32'(obs_run[0]), 32'h0040);
      checkOutput("memory kept imm", 32'(obs_next[0]), 32'h00A5);
    end else checkOutput("post-reset runs", 32'(obs_run.size()), 32'd1);

    // Address wrap on a 4-word memory: the mvi at address 3 takes its immediate from address 0.
    load_word_w(2'd0, 16'hA440);
    load_word_w(2'd1, HALT_WORD);
    load_word_w(2'd2, 16'h0008);
    load_word_w(2'd3, 16'h0040);
    start_w = 1'b1; step(); start_w = 1'b0;
    last_run = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (halted_w) break;
      if (last_run) wnext.push_back(din_w);
      if (run_w) wrun.push_back(din_w);
      done_w = last_run;
      last_run = run_w;
      step();
    end
    done_w = 1'b0;
    checkOutput("wrap runs", 32'(wrun.size()), 32'd3);
    if (wrun.size() == 3 && wnext.size() == 3) begin
      checkOutput("wrap last instr", 32'(wrun[2]), 32'h0040);
      checkOutput("wrap immediate", 32'(wnext[2]), 32'hA440);
    end
    checkOutput("wrap PC", 32'(pc_w), 32'd1);
    checkOutput("wrap InstrCount", 32'(instr_count_w), 32'd3);
    checkOutput("wrap Halted", 32'(halted_w), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
